uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver and the next generation of the board's serial-input path. Converts an asynchronous `rx` line into parallel words, with configurable word length, parity and stop bits. Synchronises the input, majority-votes each bit, and reports parity, framing and overrun errors. Delivers each word over a valid/ready handshake, so downstream logic (display driver, command parser) can stall without corrupting reception.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `DATA_BITS`, 8: word length, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk_50mhz` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line; idles high.
- `rx_data` out DATA_BITS: received word, LSB = first bit on the line.
- `rx_valid` out 1: `rx_data` and the error flags are valid.
- `rx_ready` in 1: the consumer accepts the word on `rx_valid & rx_ready`.
- `parity_err` out 1: parity mismatch for the held word; always 0 when `PARITY`=0.
- `frame_err` out 1: at least one stop bit sampled low for the held word.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.

## Operation
- **Synchroniser:** `rx` passes through two flops to give `rx_s`. Both flops reset to 1.
- **Tick generator:**
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor.
  - Free-running; produces a one-cycle `tick` every DIV clocks.
  - Counter resets to 0.
- **FSM** (states IDLE, START, DATA, PARITY, STOP):
  - **IDLE:** a falling edge on `rx_s` (previous 1, current 0) moves to START with `tcnt`=0. A line held low never retriggers.
  - **START:** count ticks. At `tcnt`=OVERSAMPLE/2-1, if `rx_s`=1 it is a false start: return to IDLE. Otherwise clear `tcnt` and go to DATA. Sampling is now bit-centred.
  - **DATA:**
    - `tcnt` counts 0..OVERSAMPLE-1 per bit.
    - The bit value is the majority of `rx_s` at `tcnt` = OVERSAMPLE-3, -2, -1.
    - Bits shift in LSB first.
    - After DATA_BITS bits, go to PARITY if `PARITY`≠0, else to STOP.
  - **PARITY:** sample one bit the same way. Mismatch against the odd/even parity of the data sets the internal `perr`.
  - **STOP:**
    - Sample STOP_BITS bits; any sampled 0 sets the internal `ferr`.
    - At the final stop sample, go to IDLE in the same cycle. Back-to-back frames are therefore allowed.
- **Completion** (at the final stop sample):
  - If `rx_valid`=0, or a handshake occurs in the same cycle: load `rx_data`/`parity_err`/`frame_err` and set `rx_valid`.
  - Otherwise pulse `overrun`; the new word is discarded and the held word is unchanged.
- **Handshake:** `rx_valid` clears on `rx_valid & rx_ready` unless a completion lands in the same cycle. In that case it stays 1 with the new word.
- A frame with `frame_err` is still delivered. The FSM then waits in IDLE for `rx_s` to return high before detecting a new start edge (break tolerance).

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0. FSM in IDLE, counters 0, synchroniser 11.
- **Reset mid-frame:** the partial word is discarded. Outputs take their reset values on the first clock edge with `reset`=1.
- **Input latency:** `rx` to `rx_s` is 2 clocks.
- **Start-edge uncertainty:** up to 1 tick, because the tick generator is not phase-aligned to the start edge.
- **Output latency:** `rx_valid` rises 1 clock after the tick of the final stop sample.
- **Error flags:** change only when `rx_valid` is loaded.
- **Ready path:** no combinational path from `rx_ready` to any output.
- **Counter widths:** `tcnt` is $clog2(OVERSAMPLE) bits; bit counter is $clog2(DATA_BITS+1) bits; divider is $clog2(DIV) bits.

## Structure
- **Package `uart_pkg`:** FSM state enum, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and a DIV-computation function. Shared with the future `uart_tx_param`.
- **Sub-module `uart_baud_tick`:** tick divider, parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE. Reusable by the transmitter.

## Test plan
Defaults unless stated; DIV=27; bit period = 432 clocks.
- **Basic receive:** 8N1 frame 0x55, `rx_ready`=1 → one-cycle `rx_valid`, `rx_data`=0x55, all error flags 0.
- **Parity error:** `PARITY`=2, `DATA_BITS`=8, send 0xA3 with parity bit 1 (correct bit is 0) → `rx_data`=0xA3, `parity_err`=1. Same frame with parity bit 0 → `parity_err`=0.
- **Framing error and break:** frame 0x3C with stop bit 0 → `frame_err`=1, `rx_data`=0x3C. Hold `rx` low for 20 bit times → no further `rx_valid`. Release, then send 0x81 → received cleanly.
- **Glitch rejection:** `rx` low for 100 clocks (less than half a bit), then high → no `rx_valid`, FSM back in IDLE; the next frame 0x7E is received correctly.
- **Overrun:** `rx_ready`=0, back-to-back frames 0x12 then 0x34 → `rx_valid` held with 0x12; `overrun` pulses once at the second frame's stop sample. Then `rx_ready`=1 → 0x12 accepted, `rx_valid` drops.
- **Reset mid-frame:** assert `reset` for 1 clock during data bit 4 → outputs 0 on the next edge. A following 7E2 frame (`DATA_BITS`=7, `STOP_BITS`=2) carrying 0x43 → `rx_data`=0x43, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and baud divider math.
// Intended for both the receiver and the upcoming transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake bundle: the receiver drives word, valid and error flags,
// the consumer drives ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider: one-cycle tick_o every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, majority-voted sampling, word delivered
// over valid/ready with parity, framing and overrun reporting.
//   state     | meaning
//   ST_IDLE   | waiting for a 1->0 edge on the synchronised line
//   ST_START  | half-bit check of the start bit, rejects glitches
//   ST_DATA   | shifting in data bits, LSB first
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | sampling stop bits; last sample completes the word
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk_50mhz,
    input  logic            reset,
    input  logic            rx,
    uart_rx_param_if.master rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TCNT_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TCNT_V0   = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] TCNT_V1   = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] TCNT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BCNT_DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BCNT_STOP_LAST = BW'(STOP_BITS - 1);

    logic tick;

    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_prev_q;

    uart_state_e          state_q,   state_d;
    logic [TW-1:0]        tcnt_q,    tcnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q,    vote_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 perr_q,    perr_d;
    logic                 ferr_q,    ferr_d;

    logic bit_end;
    logic bit_val;
    logic complete;
    logic word_ferr;

    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
    logic                 handshake;
    logic                 load;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk_i   (clk_50mhz),
        .reset_i (reset),
        .tick_o  (tick)
    );

    assign rx_s = sync_q[1];

    // rx_prev_q tracks the line in every state so a stuck-low line never looks like a new edge
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            bit_cnt_q <= '0;
            vote_q    <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_cnt_q <= bit_cnt_d;
            vote_q    <= vote_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bit_cnt_d = bit_cnt_q;
        vote_d    = vote_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        complete  = 1'b0;
        word_ferr = ferr_q;
        bit_end   = tick && (tcnt_q == TCNT_LAST);
        bit_val   = maj3(vote_q[0], vote_q[1], rx_s);

        unique case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d   = ST_START;
                    tcnt_d    = '0;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == TCNT_HALF) begin
                        tcnt_d  = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == TCNT_V0) vote_d[0] = rx_s;
                    if (tcnt_q == TCNT_V1) vote_d[1] = rx_s;
                    tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + 1'b1;
                end
                if (bit_end) begin
                    if (state_q == ST_DATA) begin
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BCNT_DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (state_q == ST_PARITY) begin
                        // odd mode expects XOR of data+parity = 1, even mode expects 0
                        perr_d  = (^{shift_q, bit_val}) ^ (PARITY == PAR_ODD);
                        state_d = ST_STOP;
                    end else begin
                        ferr_d    = ferr_q | ~bit_val;
                        word_ferr = ferr_d;
                        if (bit_cnt_q == BCNT_STOP_LAST) begin
                            complete  = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A completion may replace a word that is being accepted in the same cycle
    always_comb begin
        handshake    = rx_valid_q & rx_if.rx_ready;
        load         = complete & (~rx_valid_q | rx_if.rx_ready);
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = complete & ~load;
        if (handshake) begin
            rx_valid_d = 1'b0;
        end
        if (load) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = word_ferr;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 7E2) driven with serial frames,
// received words compared against a frame-level reference model.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int BIT_CLKS = 432;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // captured words: {frame_err, parity_err, data zero-extended to 9 bits}
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];
    int valid_cyc_a = 0;
    int ovr_cnt_a   = 0;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();
    uart_rx_param_if #(.DATA_BITS(7)) if_c ();

    assign if_a.rx_ready = ready_a;
    assign if_b.rx_ready = ready_b;
    assign if_c.rx_ready = ready_c;

    uart_rx_param u_a (.clk_50mhz(clk_50mhz), .reset(reset), .rx(rx_a), .rx_if(if_a));
    uart_rx_param #(.PARITY(PAR_EVEN)) u_b (.clk_50mhz(clk_50mhz), .reset(reset), .rx(rx_b), .rx_if(if_b));
    uart_rx_param #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_c (
        .clk_50mhz(clk_50mhz), .reset(reset), .rx(rx_c), .rx_if(if_c));

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (!reset) begin
            if (if_a.rx_valid && if_a.rx_ready)
                q_a.push_back({if_a.frame_err, if_a.parity_err, 1'b0, if_a.rx_data});
            if (if_b.rx_valid && if_b.rx_ready)
                q_b.push_back({if_b.frame_err, if_b.parity_err, 1'b0, if_b.rx_data});
            if (if_c.rx_valid && if_c.rx_ready)
                q_c.push_back({if_c.frame_err, if_c.parity_err, 2'b00, if_c.rx_data});
            if (if_a.rx_valid) valid_cyc_a++;
            if (if_a.overrun) ovr_cnt_a++;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 4000000", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference: what a receiver must report for a given line frame
    function automatic logic [10:0] model_word(input logic [8:0] data, input int nbits, input int par_mode,
                                               input logic pbit, input logic [1:0] stopv, input int nstop);
        logic [8:0] d;
        int         ones;
        logic       perr;
        logic       ferr;
        d    = '0;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            d[i] = data[i];
            ones += int'(data[i]);
        end
        perr = 1'b0;
        if (par_mode == PAR_ODD)  perr = (((ones + int'(pbit)) % 2) != 1);
        if (par_mode == PAR_EVEN) perr = (((ones + int'(pbit)) % 2) != 0);
        ferr = (stopv[0] == 1'b0) || (nstop == 2 && stopv[1] == 1'b0);
        return {ferr, perr, d};
    endfunction

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic drive_bit(input int inst, input logic v);
        set_line(inst, v);
        repeat (BIT_CLKS) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic idle_bits(input int inst, input int n);
        set_line(inst, 1'b1);
        repeat (n * BIT_CLKS) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits, input int has_par,
                              input logic pbit, input int nstop, input logic [1:0] stopv);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(inst, data[i]);
        if (has_par != 0) drive_bit(inst, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(inst, stopv[i]);
    endtask

    task automatic wait_word(input int inst, input int max_cyc, output bit got, output logic [10:0] w);
        got = 1'b0;
        w   = '0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            if (inst == 0 && q_a.size() > 0) begin w = q_a.pop_front(); got = 1'b1; end
            else if (inst == 1 && q_b.size() > 0) begin w = q_b.pop_front(); got = 1'b1; end
            else if (inst == 2 && q_c.size() > 0) begin w = q_c.pop_front(); got = 1'b1; end
            if (!got) begin
                @(negedge clk_50mhz);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk_50mhz);
        #1;
        n_tests++;
        if ({if_a.rx_valid, if_a.parity_err, if_a.frame_err, if_a.overrun, if_a.rx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got %h expected 000",
                     {if_a.rx_valid, if_a.parity_err, if_a.frame_err, if_a.overrun, if_a.rx_data});
        end
        n_tests++;
        if ({if_b.rx_valid, if_b.parity_err, if_b.frame_err, if_b.overrun, if_b.rx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got %h expected 000",
                     {if_b.rx_valid, if_b.parity_err, if_b.frame_err, if_b.overrun, if_b.rx_data});
        end
        n_tests++;
        if ({if_c.rx_valid, if_c.parity_err, if_c.frame_err, if_c.overrun, if_c.rx_data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_c_outputs: got %h expected 000",
                     {if_c.rx_valid, if_c.parity_err, if_c.frame_err, if_c.overrun, if_c.rx_data});
        end
        n_tests++;
        if (u_a.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", u_a.state_q, ST_IDLE);
        end
        reset = 1'b0;
        idle_bits(0, 1);
    endtask

    task automatic test_basic();
        logic [10:0] w, exp;
        bit got;
        int v0;
        q_a.delete();
        ready_a = 1'b1;
        v0 = valid_cyc_a;
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11);
        idle_bits(0, 1);
        wait_word(0, 4 * BIT_CLKS, got, w);
        exp = model_word(9'h055, 8, PAR_NONE, 1'b0, 2'b11, 1);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL basic_word: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL basic_word: got %h expected %h", w, exp); end
        n_tests++;
        if ((valid_cyc_a - v0) !== 1) begin
            n_fail++;
            $display("FAIL basic_valid_width: got %0d cycles expected 1", valid_cyc_a - v0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] w, exp;
        bit got;
        q_b.delete();
        for (int k = 0; k < 2; k++) begin
            logic pbit;
            pbit = (k == 0) ? 1'b1 : 1'b0;
            send_frame(1, 9'h0A3, 8, 1, pbit, 1, 2'b11);
            idle_bits(1, 1);
            wait_word(1, 4 * BIT_CLKS, got, w);
            exp = model_word(9'h0A3, 8, PAR_EVEN, pbit, 2'b11, 1);
            n_tests++;
            if (!got) begin n_fail++; $display("FAIL parity_p%0d: got none expected %h", pbit, exp); end
            else if (w !== exp) begin n_fail++; $display("FAIL parity_p%0d: got %h expected %h", pbit, w, exp); end
        end
    endtask

    task automatic test_framing_break();
        logic [10:0] w, exp;
        bit got;
        q_a.delete();
        ready_a = 1'b1;
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00);
        set_line(0, 1'b0);
        repeat (20 * BIT_CLKS) @(posedge clk_50mhz);
        #1;
        wait_word(0, 1, got, w);
        exp = model_word(9'h03C, 8, PAR_NONE, 1'b0, 2'b00, 1);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL frame_err_word: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL frame_err_word: got %h expected %h", w, exp); end
        n_tests++;
        if (q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL break_no_retrigger: got %0d extra words expected 0", q_a.size());
        end
        idle_bits(0, 2);
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
        idle_bits(0, 1);
        wait_word(0, 4 * BIT_CLKS, got, w);
        exp = model_word(9'h081, 8, PAR_NONE, 1'b0, 2'b11, 1);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL after_break_word: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL after_break_word: got %h expected %h", w, exp); end
    endtask

    task automatic test_glitch();
        logic [10:0] w, exp;
        bit got;
        q_a.delete();
        set_line(0, 1'b0);
        repeat (100) @(posedge clk_50mhz);
        #1;
        idle_bits(0, 3);
        n_tests++;
        if (q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_no_word: got %0d words expected 0", q_a.size());
        end
        n_tests++;
        if (u_a.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL glitch_idle: got state %0d expected %0d", u_a.state_q, ST_IDLE);
        end
        send_frame(0, 9'h07E, 8, 0, 1'b0, 1, 2'b11);
        idle_bits(0, 1);
        wait_word(0, 4 * BIT_CLKS, got, w);
        exp = model_word(9'h07E, 8, PAR_NONE, 1'b0, 2'b11, 1);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL glitch_next_word: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL glitch_next_word: got %h expected %h", w, exp); end
    endtask

    task automatic test_overrun();
        logic [10:0] w, exp;
        bit got;
        int o0;
        q_a.delete();
        ready_a = 1'b0;
        o0 = ovr_cnt_a;
        send_frame(0, 9'h012, 8, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h034, 8, 0, 1'b0, 1, 2'b11);
        idle_bits(0, 1);
        n_tests++;
        if ({if_a.rx_valid, if_a.rx_data} !== 9'h112) begin
            n_fail++;
            $display("FAIL overrun_held: got valid/data %h expected 112", {if_a.rx_valid, if_a.rx_data});
        end
        n_tests++;
        if ((ovr_cnt_a - o0) !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt_a - o0);
        end
        ready_a = 1'b1;
        wait_word(0, 8, got, w);
        exp = model_word(9'h012, 8, PAR_NONE, 1'b0, 2'b11, 1);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL overrun_accept: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL overrun_accept: got %h expected %h", w, exp); end
        @(posedge clk_50mhz);
        #1;
        n_tests++;
        if (if_a.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_valid_drop: got %b expected 0", if_a.rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] w, exp;
        logic [7:0]  part;
        bit got;
        q_a.delete();
        ready_a = 1'b0;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        idle_bits(0, 1);
        n_tests++;
        if ({if_a.rx_valid, if_a.rx_data} !== 9'h1A5) begin
            n_fail++;
            $display("FAIL rst_preload: got valid/data %h expected 1a5", {if_a.rx_valid, if_a.rx_data});
        end
        part = 8'($urandom_range(255, 0));
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, part[i]);
        set_line(0, part[4]);
        repeat (BIT_CLKS / 2) @(posedge clk_50mhz);
        #1;
        reset = 1'b1;
        @(posedge clk_50mhz);
        #1;
        n_tests++;
        if ({if_a.rx_valid, if_a.parity_err, if_a.frame_err, if_a.overrun, if_a.rx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 000",
                     {if_a.rx_valid, if_a.parity_err, if_a.frame_err, if_a.overrun, if_a.rx_data});
        end
        reset = 1'b0;
        idle_bits(0, 8);
        n_tests++;
        if (if_a.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_partial_discarded: got valid %b expected 0", if_a.rx_valid);
        end
        ready_a = 1'b1;
        q_c.delete();
        send_frame(2, 9'h043, 7, 1, 1'b1, 2, 2'b11);
        idle_bits(2, 1);
        wait_word(2, 4 * BIT_CLKS, got, w);
        exp = model_word(9'h043, 7, PAR_EVEN, 1'b1, 2'b11, 2);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL rst_7e2_word: got none expected %h", exp); end
        else if (w !== exp) begin n_fail++; $display("FAIL rst_7e2_word: got %h expected %h", w, exp); end
    endtask

    task automatic test_random();
        logic [10:0] exp_a[$];
        logic [10:0] exp_b[$];
        logic [10:0] w;
        bit got;
        q_a.delete();
        q_b.delete();
        ready_a = 1'b1;
        ready_b = 1'b1;
        fork
            for (int i = 0; i < 2; i++) begin
                logic [8:0] d;
                d = 9'($urandom_range(255, 0));
                exp_a.push_back(model_word(d, 8, PAR_NONE, 1'b0, 2'b11, 1));
                send_frame(0, d, 8, 0, 1'b0, 1, 2'b11);
            end
            for (int i = 0; i < 2; i++) begin
                logic [8:0] d;
                logic       p;
                logic [1:0] s;
                d = 9'($urandom_range(255, 0));
                p = 1'($urandom_range(1, 0));
                s = ($urandom_range(3, 0) == 0) ? 2'b00 : 2'b11;
                exp_b.push_back(model_word(d, 8, PAR_EVEN, p, s, 1));
                send_frame(1, d, 8, 1, p, 1, s);
                idle_bits(1, 1);
            end
        join
        idle_bits(0, 1);
        for (int i = 0; i < 2; i++) begin
            wait_word(0, 2, got, w);
            n_tests++;
            if (!got) begin n_fail++; $display("FAIL rand_a%0d: got none expected %h", i, exp_a[i]); end
            else if (w !== exp_a[i]) begin n_fail++; $display("FAIL rand_a%0d: got %h expected %h", i, w, exp_a[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            wait_word(1, 2, got, w);
            n_tests++;
            if (!got) begin n_fail++; $display("FAIL rand_b%0d: got none expected %h", i, exp_b[i]); end
            else if (w !== exp_b[i]) begin n_fail++; $display("FAIL rand_b%0d: got %h expected %h", i, w, exp_b[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing_break();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
